kara81_pp_gen: RTL and testbench

//  Upstream partial-product generator for the 81-bit GF(2)[x] Karatsuba multiplier.

---
 rtl/kara81_pp_gen_if.sv | 14 +
 rtl/kara81_pp_gen.sv | 143 ++++++++++++++
 tb/tb_kara81_pp_gen.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/kara81_pp_gen_if.sv
// Request/status bundle for the Karatsuba partial-product generator:
// operand handshake (start, a, b) plus busy/done status.
interface kara81_pp_gen_if #(
  parameter int unsigned W = 27
);
  logic           start;
  logic [3*W-1:0] a;
  logic [3*W-1:0] b;
  logic           busy;
  logic           done;

  modport master (output start, a, b, input busy, done);
  modport slave  (input start, a, b, output busy, done);
endinterface

// File: rtl/kara81_pp_gen.sv
// Six-product Karatsuba partial-product generator for 3-chunk GF(2)[x] operands.
// Build option PP_SERIAL_EN selects a bit-serial shared multiplier (W cycles per product).
module kara81_pp_gen #(
  parameter int unsigned W = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  kara81_pp_gen_if.slave        bus,
  output logic [2*W-2:0]        p0,
  output logic [2*W-2:0]        p1,
  output logic [2*W-2:0]        p2,
  output logic [2*W-2:0]        p3,
  output logic [2*W-2:0]        p4,
  output logic [2*W-2:0]        p5
);

  localparam int unsigned PW = 2 * W - 1;
  localparam int unsigned OW = 3 * W;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t          state;
  logic [OW-1:0]   a_q;
  logic [OW-1:0]   b_q;
  logic [2:0]      idx;
  logic            busy_q;
  logic            done_q;
  logic [PW-1:0]   p_q [6];

  logic [W-1:0]    ca_c;
  logic [W-1:0]    cb_c;
  logic            pair_done_c;
  logic [PW-1:0]   pair_val_c;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign p0 = p_q[0];
  assign p1 = p_q[1];
  assign p2 = p_q[2];
  assign p3 = p_q[3];
  assign p4 = p_q[4];
  assign p5 = p_q[5];

  // Chunk pair feeding the shared multiplier for the current product index
  always_comb begin
    ca_c = '0;
    cb_c = '0;
    case (idx)
      3'd0: begin ca_c = a_q[W-1:0];                  cb_c = b_q[W-1:0];                  end
      3'd1: begin ca_c = a_q[2*W-1:W];                cb_c = b_q[2*W-1:W];                end
      3'd2: begin ca_c = a_q[W-1:0] ^ a_q[2*W-1:W];   cb_c = b_q[W-1:0] ^ b_q[2*W-1:W];   end
      3'd3: begin ca_c = a_q[3*W-1:2*W];              cb_c = b_q[3*W-1:2*W];              end
      3'd4: begin ca_c = a_q[W-1:0] ^ a_q[3*W-1:2*W]; cb_c = b_q[W-1:0] ^ b_q[3*W-1:2*W]; end
      3'd5: begin ca_c = a_q[2*W-1:W] ^ a_q[3*W-1:2*W]; cb_c = b_q[2*W-1:W] ^ b_q[3*W-1:2*W]; end
      default: begin ca_c = '0; cb_c = '0; end
    endcase
  end

`ifdef PP_SERIAL_EN
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  logic [CW-1:0] cnt;
  logic [PW-1:0] acc;
  logic [PW-1:0] acc_base_c;

  // MSB-first shift/xor step; accumulator restarts at the first bit of each pair
  always_comb begin
    acc_base_c  = (cnt == '0) ? '0 : acc;
    pair_val_c  = {acc_base_c[PW-2:0], 1'b0} ^ (cb_c[CW'(W-1) - cnt] ? PW'(ca_c) : '0);
    pair_done_c = (cnt == CW'(W-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (state == S_MUL) begin
      acc <= pair_val_c;
      cnt <= pair_done_c ? '0 : cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end
`else
  function automatic logic [PW-1:0] clmul_w(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [PW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (y[i]) r = r ^ (PW'(x) << i);
    end
    return r;
  endfunction

  always_comb begin
    pair_val_c  = clmul_w(ca_c, cb_c);
    pair_done_c = 1'b1;
  end
`endif

  // Control FSM; done is raised one edge after the DONE state is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < 6; i++) p_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= S_MUL;
          end
        end
        S_MUL: begin
          if (pair_done_c) begin
            p_q[idx] <= pair_val_c;
            if (idx == 3'd5) begin
              busy_q <= 1'b0;
              state  <= S_DONE;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
          idx    <= '0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kara81_pp_gen.sv
// Directed/random bench for kara81_pp_gen; honours PP_SERIAL_EN for latency expectations.
module tb_kara81_pp_gen;

  localparam int W  = 27;
  localparam int PW = 2 * W - 1;
  localparam int OW = 3 * W;
`ifdef PP_SERIAL_EN
  localparam int LAT    = 1 + 6 * W;
  localparam int IDX3_T = 3 * W;
`else
  localparam int LAT    = 7;
  localparam int IDX3_T = 3;
`endif
  localparam int BUSY_N = LAT - 1;
  localparam int LIMIT  = LAT + 20;

  logic clk = 1'b0;
  logic rst_n;
  logic [PW-1:0] p0, p1, p2, p3, p4, p5;
  logic [5:0][PW-1:0] pv;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  kara81_pp_gen_if #(.W(W)) bus ();

  kara81_pp_gen #(.W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .p0   (p0),
    .p1   (p1),
    .p2   (p2),
    .p3   (p3),
    .p4   (p4),
    .p5   (p5)
  );

  assign pv = {p5, p4, p3, p2, p1, p0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Definitional W x W carry-less product: bit k = parity of x[i]&y[k-i]
  function automatic logic [PW-1:0] cm_chunk(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < PW; k++)
      for (int i = 0; i < W; i++)
        if ((k - i) >= 0 && (k - i) < W) r[k] = r[k] ^ (x[i] & y[k-i]);
    return r;
  endfunction

  function automatic logic [2*OW-2:0] cm_full(input logic [OW-1:0] x, input logic [OW-1:0] y);
    logic [2*OW-2:0] r;
    r = '0;
    for (int i = 0; i < OW; i++)
      if (y[i]) r = r ^ ((2*OW-1)'(x) << i);
    return r;
  endfunction

  function automatic logic [5:0][PW-1:0] pp_ref(input logic [OW-1:0] x, input logic [OW-1:0] y);
    logic [W-1:0] x0, x1, x2, y0, y1, y2;
    logic [5:0][PW-1:0] e;
    {x2, x1, x0} = x;
    {y2, y1, y0} = y;
    e[0] = cm_chunk(x0, y0);
    e[1] = cm_chunk(x1, y1);
    e[2] = cm_chunk(x0 ^ x1, y0 ^ y1);
    e[3] = cm_chunk(x2, y2);
    e[4] = cm_chunk(x0 ^ x2, y0 ^ y2);
    e[5] = cm_chunk(x1 ^ x2, y1 ^ y2);
    return e;
  endfunction

  function automatic logic [2*OW-2:0] recomb(input logic [5:0][PW-1:0] p);
    logic [2*OW-2:0] r;
    r = (2*OW-1)'(p[0]);
    r = r ^ ((2*OW-1)'(p[2] ^ p[0] ^ p[1]) << W);
    r = r ^ ((2*OW-1)'(p[4] ^ p[0] ^ p[3] ^ p[1]) << (2*W));
    r = r ^ ((2*OW-1)'(p[5] ^ p[1] ^ p[3]) << (3*W));
    r = r ^ ((2*OW-1)'(p[3]) << (4*W));
    return r;
  endfunction

  function automatic logic [OW-1:0] rnd81();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[OW-1:0];
  endfunction

  // Issue one operation at a negedge; returns at the negedge where done is seen
  task automatic run_op(input logic [OW-1:0] av, input logic [OW-1:0] bv,
                        output int lat, output int bcnt, output bit ok);
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!bus.done && lat < LIMIT) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    ok = bus.done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    nvec++; if (pv !== '0) begin nerr++; $display("FAIL reset_p got=%h exp=0", pv); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unit();
    int lat, bcnt;
    bit ok;
    logic [5:0][PW-1:0] e;
    e = {PW'(0), PW'(1), PW'(0), PW'(1), PW'(0), PW'(1)};
    run_op(OW'(1), OW'(1), lat, bcnt, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL unit_timeout got=no_done exp=done"); end
    nvec++; if (lat !== LAT) begin nerr++; $display("FAIL unit_latency got=%0d exp=%0d", lat, LAT); end
    nvec++; if (bcnt !== BUSY_N) begin nerr++; $display("FAIL unit_busy_cycles got=%0d exp=%0d", bcnt, BUSY_N); end
    nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL unit_busy_at_done got=%b exp=0", bus.busy); end
    nvec++; if (pv !== e) begin nerr++; $display("FAIL unit_p got=%h exp=%h", pv, e); end
    @(negedge clk);
    nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL unit_done_pulse got=%b exp=0", bus.done); end
  endtask

  task automatic test_all_ones();
    int lat, bcnt;
    bit ok;
    logic [PW-1:0] c;
    logic [5:0][PW-1:0] e;
    c = 53'h15555555555555;
    e = {PW'(0), PW'(0), c, PW'(0), c, c};
    run_op('1, '1, lat, bcnt, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL ones_timeout got=no_done exp=done"); end
    for (int k = 0; k < 6; k++) begin
      nvec++;
      if (pv[k] !== e[k]) begin nerr++; $display("FAIL ones_p%0d got=%h exp=%h", k, pv[k], e[k]); end
    end
  endtask

  task automatic test_msb();
    int lat, bcnt;
    bit ok;
    logic [PW-1:0] m;
    logic [5:0][PW-1:0] e;
    m = PW'(1) << 52;
    e = {m, m, m, PW'(0), PW'(0), PW'(0)};
    run_op(OW'(1) << 80, OW'(1) << 80, lat, bcnt, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL msb80_timeout got=no_done exp=done"); end
    nvec++; if (pv !== e) begin nerr++; $display("FAIL msb80_p got=%h exp=%h", pv, e); end
    e = {m, PW'(0), PW'(0), m, m, PW'(0)};
    run_op(OW'(1) << 53, OW'(1) << 53, lat, bcnt, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL msb53_timeout got=no_done exp=done"); end
    nvec++; if (pv !== e) begin nerr++; $display("FAIL msb53_p got=%h exp=%h", pv, e); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt, prev;
    bit ok;
    logic [OW-1:0] av, bv;
    logic [5:0][PW-1:0] e;
    prev = 0;
    for (int n = 0; n < 200; n++) begin
      av = rnd81();
      bv = rnd81();
      e = pp_ref(av, bv);
      run_op(av, bv, lat, bcnt, ok);
      nvec++; if (!ok) begin nerr++; $display("FAIL b2b_timeout[%0d] got=no_done exp=done", n); end
      nvec++; if (pv !== e) begin nerr++; $display("FAIL b2b_p[%0d] got=%h exp=%h", n, pv, e); end
      nvec++;
      if (recomb(pv) !== cm_full(av, bv)) begin
        nerr++; $display("FAIL b2b_prod[%0d] got=%h exp=%h", n, recomb(pv), cm_full(av, bv));
      end
      if (n > 0) begin
        nvec++;
        if (cyc - prev !== LAT + 1) begin nerr++; $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", n, cyc - prev, LAT + 1); end
      end
      prev = cyc;
    end
  endtask

  task automatic test_ignore_start();
    int t, ndone, nbusy;
    logic [OW-1:0] av, bv;
    logic [5:0][PW-1:0] e;
    av = 81'h0_1234_5678_9abc_def0_1357;
    bv = 81'h1_fedc_ba98_7654_3210_2468;
    e = pp_ref(av, bv);
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.a = rnd81();
    bus.b = rnd81();
    t = 0;
    while (!bus.done && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    ndone = bus.done ? 1 : 0;
    bus.start = 1'b0;
    nvec++; if (t !== LAT) begin nerr++; $display("FAIL ign_latency got=%0d exp=%0d", t, LAT); end
    nvec++; if (pv !== e) begin nerr++; $display("FAIL ign_p got=%h exp=%h", pv, e); end
    nbusy = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (bus.busy) nbusy++;
    end
    nvec++; if (ndone !== 1) begin nerr++; $display("FAIL ign_done_count got=%0d exp=1", ndone); end
    nvec++; if (nbusy !== 0) begin nerr++; $display("FAIL ign_busy_after got=%0d exp=0", nbusy); end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, ndone;
    bit ok;
    logic [OW-1:0] av, bv;
    av = 81'h1_aaaa_5555_0f0f_f0f0_3c3c;
    bv = 81'h0_7777_1111_8888_eeee_9999;
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (IDX3_T) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
    nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL rmid_done got=%b exp=0", bus.done); end
    nvec++; if (pv !== '0) begin nerr++; $display("FAIL rmid_p got=%h exp=0", pv); end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    nvec++; if (ndone !== 0) begin nerr++; $display("FAIL rmid_stray_done got=%0d exp=0", ndone); end
    run_op(av, bv, lat, bcnt, ok);
    nvec++; if (lat !== LAT) begin nerr++; $display("FAIL rmid_relat got=%0d exp=%0d", lat, LAT); end
    nvec++; if (pv !== pp_ref(av, bv)) begin nerr++; $display("FAIL rmid_rep got=%h exp=%h", pv, pp_ref(av, bv)); end
  endtask

  initial begin
    test_reset();
    test_unit();
    test_all_ones();
    test_msb();
    test_back_to_back();
    @(negedge clk);
    test_ignore_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
